// File: rtl/beq_branch_sequencer.sv
// rtl/beq_branch_sequencer.sv - multi-cycle BEQ sequencer owning the PC and the shared RF/ALU ports
module beq_branch_sequencer #(
  parameter logic [31:0] PC_RESET   = 32'd100,
  parameter int          CNT_W      = 16,
  parameter logic [5:0]  BEQ_OPCODE = 6'b000100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  output logic [4:0]       rf_ra1,
  output logic [4:0]       rf_ra2,
  input  logic [31:0]      rf_rd1,
  input  logic [31:0]      rf_rd2,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_op,
  input  logic             alu_zero,
  output logic [31:0]      pc,
  output logic             done,
  output logic             taken,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, UPDATE} state_t;

  localparam logic [3:0]       ALU_SUB = 4'b0110;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t      state;
  logic [15:0] ir_imm;
  logic        is_beq;
  logic        zero_q;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic [31:0] imm_off;

  assign pc_plus4 = pc + 32'd4;
  assign imm_off  = {{14{ir_imm[15]}}, ir_imm, 2'b00};

  // Sequencer FSM; every output is registered and set on the edge entering the state that owns it,
  // so the RF address is already stable for the whole READ cycle and the ALU operands for EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= PC_RESET;
      instr_ready <= 1'b1;
      done        <= 1'b0;
      taken       <= 1'b0;
      branch_cnt  <= '0;
      taken_cnt   <= '0;
      rf_ra1      <= '0;
      rf_ra2      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      ir_imm      <= '0;
      is_beq      <= 1'b0;
      zero_q      <= 1'b0;
      target      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid && !flush) begin
            ir_imm      <= instr[15:0];
            instr_ready <= 1'b0;
            if (instr[31:26] == BEQ_OPCODE) begin
              is_beq <= 1'b1;
              rf_ra1 <= instr[25:21];
              rf_ra2 <= instr[20:16];
              state  <= READ;
            end else begin
              // Non-branch: straight to retirement with a sequential PC
              is_beq <= 1'b0;
              zero_q <= 1'b0;
              done   <= 1'b1;
              taken  <= 1'b0;
              state  <= UPDATE;
            end
          end
        end
        READ: begin
          rf_ra1 <= '0;
          rf_ra2 <= '0;
          if (flush) begin
            instr_ready <= 1'b1;
            state       <= IDLE;
          end else begin
            // alu_a/alu_b double as the latched operand registers
            alu_a  <= rf_rd1;
            alu_b  <= rf_rd2;
            alu_op <= ALU_SUB;
            state  <= EXEC;
          end
        end
        EXEC: begin
          alu_a  <= '0;
          alu_b  <= '0;
          alu_op <= '0;
          if (flush) begin
            instr_ready <= 1'b1;
            state       <= IDLE;
          end else begin
            zero_q <= alu_zero;
            target <= pc_plus4 + imm_off;
            done   <= 1'b1;
            taken  <= alu_zero;
            state  <= UPDATE;
          end
        end
        UPDATE: begin
          // Flush is deliberately ignored here: the instruction is already committed
          pc          <= (is_beq && zero_q) ? target : pc_plus4;
          done        <= 1'b0;
          taken       <= 1'b0;
          instr_ready <= 1'b1;
          state       <= IDLE;
          if (is_beq) begin
            if (branch_cnt != CNT_MAX) branch_cnt <= branch_cnt + 1'b1;
            if (zero_q && taken_cnt != CNT_MAX) taken_cnt <= taken_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beq_branch_sequencer.sv
// tb/tb_beq_branch_sequencer.sv - randomized self-checking bench for beq_branch_sequencer
module tb_beq_branch_sequencer;

  localparam int          CW    = 2;
  localparam int          CMAX  = 3;
  localparam logic [31:0] PCR   = 32'd100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [31:0]   instr = '0;
  logic [4:0]    rf_ra1, rf_ra2;
  logic [31:0]   rf_rd1, rf_rd2;
  logic [31:0]   alu_a, alu_b;
  logic [3:0]    alu_op;
  logic          alu_zero;
  logic [31:0]   pc;
  logic          done, taken;
  logic [CW-1:0] branch_cnt, taken_cnt;

  logic [31:0] regs [32];

  int passed = 0;
  int total  = 0;

  // reference model state
  logic [31:0] m_pc;
  int          m_bcnt, m_tcnt;
  logic        exp_taken;
  int          exp_k;

  // observations from the last issued instruction
  int          obs_k, obs_dones;
  logic        obs_taken;
  logic [4:0]  obs_ra1, obs_ra2;
  logic [3:0]  obs_aop;
  logic        obs_idle0;

  always #5 clk = ~clk;

  assign rf_rd1   = regs[rf_ra1];
  assign rf_rd2   = regs[rf_ra2];
  assign alu_zero = (alu_op == 4'b0110) && ((alu_a - alu_b) == 32'd0);

  beq_branch_sequencer #(.PC_RESET(PCR), .CNT_W(CW), .BEQ_OPCODE(6'b000100)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_zero(alu_zero), .pc(pc), .done(done),
    .taken(taken), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic model_reset();
    m_pc = PCR; m_bcnt = 0; m_tcnt = 0;
  endtask

  task automatic model_exec(input logic [31:0] w);
    logic        beq;
    logic [31:0] off;
    beq       = (w[31:26] == 6'b000100);
    exp_taken = beq && (regs[w[25:21]] == regs[w[20:16]]);
    exp_k     = beq ? 2 : 0;
    off       = {{16{w[15]}}, w[15:0]} * 32'd4;
    m_pc      = exp_taken ? m_pc + 32'd4 + off : m_pc + 32'd4;
    if (beq && m_bcnt < CMAX) m_bcnt++;
    if (exp_taken && m_tcnt < CMAX) m_tcnt++;
  endtask

  task automatic issue(input logic [31:0] w);
    int guard;
    guard = 0;
    while (!instr_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    instr_valid = 1'b1; instr = w;
    @(posedge clk); #1;
    instr_valid = 1'b0; instr = $urandom;
    obs_k = -1; obs_dones = 0; obs_taken = 1'b0;
    obs_ra1 = '0; obs_ra2 = '0; obs_aop = '0; obs_idle0 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 0) begin
        obs_ra1 = rf_ra1; obs_ra2 = rf_ra2;
        obs_idle0 = (rf_ra1 == 0) && (rf_ra2 == 0) && (alu_a == 0) && (alu_b == 0) && (alu_op == 0);
      end
      if (k == 1) obs_aop = alu_op;
      if (done) begin
        obs_dones++;
        obs_taken = taken;
        if (obs_k < 0) obs_k = k;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    total++; if (pc !== PCR) $display("FAIL reset_pc got %0d exp %0d", pc, PCR); else passed++;
    total++; if (instr_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", instr_ready); else passed++;
    total++; if (done !== 1'b0 || taken !== 1'b0) $display("FAIL reset_done got %b%b exp 00", done, taken); else passed++;
    total++; if (branch_cnt !== 0 || taken_cnt !== 0) $display("FAIL reset_cnt got %0d/%0d exp 0/0", branch_cnt, taken_cnt); else passed++;
    total++; if (rf_ra1 !== 0 || rf_ra2 !== 0 || alu_a !== 0 || alu_b !== 0 || alu_op !== 0)
      $display("FAIL reset_ports got ra %0d/%0d op %h exp 0", rf_ra1, rf_ra2, alu_op); else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_beq_directed();
    logic [31:0] tbl [4];
    regs[1] = 32'd15; regs[2] = 32'd10; regs[3] = 32'd10; regs[4] = 32'd10;
    tbl[0] = mk(6'b000100, 5'd1, 5'd2, 16'd4);      // not taken: 100 -> 104
    tbl[1] = mk(6'b000100, 5'd3, 5'd4, 16'd4);      // taken fwd: 104 -> 124
    tbl[2] = mk(6'b000100, 5'd3, 5'd4, 16'hFFFE);   // taken back: 124 -> 120
    tbl[3] = mk(6'b000100, 5'd3, 5'd4, 16'hFFE0);   // 120 -> FFFFFFFC
    for (int i = 0; i < 4; i++) begin
      model_exec(tbl[i]);
      issue(tbl[i]);
      total++; if (obs_ra1 !== tbl[i][25:21] || obs_ra2 !== tbl[i][20:16])
        $display("FAIL beq%0d_ra got %0d/%0d exp %0d/%0d", i, obs_ra1, obs_ra2, tbl[i][25:21], tbl[i][20:16]); else passed++;
      total++; if (obs_aop !== 4'b0110) $display("FAIL beq%0d_aluop got %h exp 6", i, obs_aop); else passed++;
      total++; if (obs_k !== exp_k || obs_dones !== 1) $display("FAIL beq%0d_latency got k=%0d n=%0d exp k=%0d n=1", i, obs_k, obs_dones, exp_k); else passed++;
      total++; if (obs_taken !== exp_taken) $display("FAIL beq%0d_taken got %b exp %b", i, obs_taken, exp_taken); else passed++;
      total++; if (pc !== m_pc) $display("FAIL beq%0d_pc got %h exp %h", i, pc, m_pc); else passed++;
      total++; if (branch_cnt !== CW'(m_bcnt) || taken_cnt !== CW'(m_tcnt))
        $display("FAIL beq%0d_cnt got %0d/%0d exp %0d/%0d", i, branch_cnt, taken_cnt, m_bcnt, m_tcnt); else passed++;
    end
  endtask

  task automatic test_non_beq();
    logic [31:0] w;
    for (int i = 0; i < 2; i++) begin
      w = mk(6'b100011, 5'($urandom), 5'($urandom), 16'($urandom));
      model_exec(w);
      issue(w);
      total++; if (obs_k !== 0 || obs_dones !== 1) $display("FAIL nonbeq%0d_latency got k=%0d n=%0d exp k=0 n=1", i, obs_k, obs_dones); else passed++;
      total++; if (obs_taken !== 1'b0) $display("FAIL nonbeq%0d_taken got %b exp 0", i, obs_taken); else passed++;
      total++; if (obs_idle0 !== 1'b1) $display("FAIL nonbeq%0d_ports got %b exp 1", i, obs_idle0); else passed++;
      total++; if (pc !== m_pc) $display("FAIL nonbeq%0d_pc got %h exp %h", i, pc, m_pc); else passed++;
      total++; if (branch_cnt !== CW'(m_bcnt) || taken_cnt !== CW'(m_tcnt))
        $display("FAIL nonbeq%0d_cnt got %0d/%0d exp %0d/%0d", i, branch_cnt, taken_cnt, m_bcnt, m_tcnt); else passed++;
    end
  endtask

  task automatic test_flush();
    logic [31:0] w;
    int          dn;
    regs[5] = 32'd7; regs[6] = 32'd7;
    w = mk(6'b000100, 5'd5, 5'd6, 16'd8);
    // flush in READ (e=0) and EXEC (e=1)
    for (int e = 0; e < 2; e++) begin
      instr_valid = 1'b1; instr = w;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      repeat (e) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      total++; if (instr_ready !== 1'b1 || alu_op !== 4'b0 || rf_ra1 !== 5'd0)
        $display("FAIL flush%0d_idle got rdy %b op %h ra %0d exp 1/0/0", e, instr_ready, alu_op, rf_ra1); else passed++;
      dn = 0;
      for (int k = 0; k < 5; k++) begin if (done) dn++; @(posedge clk); #1; end
      total++; if (dn !== 0) $display("FAIL flush%0d_done got %0d exp 0", e, dn); else passed++;
      total++; if (pc !== m_pc || branch_cnt !== CW'(m_bcnt))
        $display("FAIL flush%0d_state got pc %h cnt %0d exp %h %0d", e, pc, branch_cnt, m_pc, m_bcnt); else passed++;
    end
    // flush in IDLE blocks acceptance but keeps ready high
    instr_valid = 1'b1; instr = w; flush = 1'b1;
    @(posedge clk); #1;
    total++; if (instr_ready !== 1'b1) $display("FAIL flush_idle_ready got %b exp 1", instr_ready); else passed++;
    instr_valid = 1'b0; flush = 1'b0;
    dn = 0;
    for (int k = 0; k < 4; k++) begin if (done) dn++; @(posedge clk); #1; end
    total++; if (dn !== 0 || pc !== m_pc) $display("FAIL flush_idle_accept got done %0d pc %h exp 0 %h", dn, pc, m_pc); else passed++;
    // flush in UPDATE is ignored
    w = mk(6'b001000, 5'd1, 5'd2, 16'd3);
    model_exec(w);
    instr_valid = 1'b1; instr = w;
    @(posedge clk); #1;
    instr_valid = 1'b0; flush = 1'b1;
    total++; if (done !== 1'b1) $display("FAIL flush_upd_done got %b exp 1", done); else passed++;
    @(posedge clk); #1;
    flush = 1'b0;
    total++; if (pc !== m_pc) $display("FAIL flush_upd_pc got %h exp %h", pc, m_pc); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    regs[7] = 32'd3; regs[8] = 32'd3;
    w = mk(6'b000100, 5'd7, 5'd8, 16'd1);
    instr_valid = 1'b1; instr = w;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    total++; if (rf_ra1 !== 5'd7) $display("FAIL rstmid_read got ra1 %0d exp 7", rf_ra1); else passed++;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    total++; if (pc !== PCR || instr_ready !== 1'b1 || done !== 1'b0 || rf_ra1 !== 5'd0)
      $display("FAIL rstmid_async got pc %0d rdy %b done %b ra %0d exp 100 1 0 0", pc, instr_ready, done, rf_ra1); else passed++;
    total++; if (branch_cnt !== 0 || taken_cnt !== 0) $display("FAIL rstmid_cnt got %0d/%0d exp 0/0", branch_cnt, taken_cnt); else passed++;
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total++; if (done !== 1'b0 || pc !== PCR) $display("FAIL rstmid_after got done %b pc %0d exp 0 100", done, pc); else passed++;
  endtask

  task automatic test_saturation();
    logic [31:0] w;
    regs[9] = 32'hDEAD; regs[10] = 32'hDEAD;
    for (int i = 0; i < 5; i++) begin
      w = mk(6'b000100, 5'd9, 5'd10, 16'($urandom_range(0, 40)));
      model_exec(w);
      issue(w);
    end
    total++; if (branch_cnt !== 2'd3 || taken_cnt !== 2'd3 || m_bcnt != 3)
      $display("FAIL sat_cnt got %0d/%0d exp 3/3", branch_cnt, taken_cnt); else passed++;
    total++; if (pc !== m_pc) $display("FAIL sat_pc got %h exp %h", pc, m_pc); else passed++;
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic [5:0]  op;
    for (int i = 0; i < 24; i++) begin
      for (int r = 0; r < 32; r++) regs[r] = 32'($urandom_range(0, 3));
      op = ($urandom_range(0, 1) == 1) ? 6'b000100 : 6'($urandom_range(5, 63));
      w  = mk(op, 5'($urandom), 5'($urandom), 16'($urandom));
      model_exec(w);
      issue(w);
      total++; if (obs_k !== exp_k || obs_dones !== 1 || obs_taken !== exp_taken)
        $display("FAIL rnd%0d_retire got k=%0d n=%0d t=%b exp k=%0d n=1 t=%b", i, obs_k, obs_dones, obs_taken, exp_k, exp_taken); else passed++;
      total++; if (pc !== m_pc || branch_cnt !== CW'(m_bcnt) || taken_cnt !== CW'(m_tcnt))
        $display("FAIL rnd%0d_state got pc %h cnt %0d/%0d exp %h %0d/%0d", i, pc, branch_cnt, taken_cnt, m_pc, m_bcnt, m_tcnt); else passed++;
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) regs[r] = '0;
    test_reset();
    test_beq_directed();
    test_non_beq();
    test_flush();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
